// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
// Holds the frame FSM state encoding, parity-mode codes and a frame-length helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_NONE = 2;

    // Falling clock edges per frame: start + data + optional parity + stop.
    function automatic int ps2_frame_len(input int data_w, input int parity_mode);
        return data_w + 2 + ((parity_mode != PAR_NONE) ? 1 : 0);
    endfunction

endpackage

// File: rtl/ps2_rx_frame_edge_filt.sv
// Pin synchroniser and PS2_CLK glitch filter; emits a one-cycle strobe on each
// filtered falling clock edge together with the synchronised data level.
module ps2_edge_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fe,
    output logic dat
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic                   clk_filt_reg;
    logic [CNT_W-1:0]       filt_cnt_reg;
    logic                   fe_reg;
    logic                   clk_smp;

    assign clk_smp = clk_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_reg <= '1;
            dat_sync_reg <= '1;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ps2_dat};
        end
    end

    // The counter tracks a run of samples disagreeing with the filtered level;
    // any agreeing sample restarts the run, so short glitches never propagate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt_reg <= 1'b1;
            filt_cnt_reg <= '0;
            fe_reg       <= 1'b0;
        end else if (clk_smp != clk_filt_reg) begin
            if (filt_cnt_reg == CNT_W'(FILT_LEN - 1)) begin
                clk_filt_reg <= clk_smp;
                filt_cnt_reg <= '0;
                fe_reg       <= clk_filt_reg & ~clk_smp;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + CNT_W'(1);
                fe_reg       <= 1'b0;
            end
        end else begin
            filt_cnt_reg <= '0;
            fe_reg       <= 1'b0;
        end
    end

    assign fe  = fe_reg;
    assign dat = dat_sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: frame FSM, data shifter, inter-edge
// watchdog and a one-entry valid/ready holding buffer with status pulses.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic              CLKOUT,
    input  logic              RST_N,
    input  logic              PS2_CLK,
    input  logic              PS2_DAT,
    output logic [DATA_W-1:0] DATA,
    output logic              VALID,
    input  logic              READY,
    output logic              PAR_ERR,
    output logic              FRM_ERR,
    output logic              OVERRUN,
    output logic              TIMEOUT
);

    localparam int   WD_W       = $clog2(TIMEOUT_CYC + 1);
    localparam int   CNT_W      = $clog2(DATA_W + 1);
    localparam logic PAR_TARGET = (PARITY_MODE == PAR_ODD);

    logic fe;
    logic dat;

    ps2_edge_filt #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_edge_filt (
        .clk    (CLKOUT),
        .rst_n  (RST_N),
        .ps2_clk(PS2_CLK),
        .ps2_dat(PS2_DAT),
        .fe     (fe),
        .dat    (dat)
    );

    ps2_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              pbit_reg, pbit_next;
    logic [WD_W-1:0]   wdog_reg, wdog_next;
    logic              par_err_reg, par_err_next;
    logic              frm_err_reg, frm_err_next;
    logic              tmo_reg, tmo_next;
    logic              pend_reg, pend_next;
    logic [DATA_W-1:0] pend_data_reg, pend_data_next;
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;
    logic              ovr_reg;
    logic              par_ok;

    assign par_ok = (PARITY_MODE == PAR_NONE) || (((^shift_reg) ^ pbit_reg) == PAR_TARGET);

    always_ff @(posedge CLKOUT or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            pbit_reg      <= 1'b0;
            wdog_reg      <= '0;
            par_err_reg   <= 1'b0;
            frm_err_reg   <= 1'b0;
            tmo_reg       <= 1'b0;
            pend_reg      <= 1'b0;
            pend_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            pbit_reg      <= pbit_next;
            wdog_reg      <= wdog_next;
            par_err_reg   <= par_err_next;
            frm_err_reg   <= frm_err_next;
            tmo_reg       <= tmo_next;
            pend_reg      <= pend_next;
            pend_data_reg <= pend_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        pbit_next      = pbit_reg;
        wdog_next      = '0;
        par_err_next   = 1'b0;
        frm_err_next   = 1'b0;
        tmo_next       = 1'b0;
        pend_next      = 1'b0;
        pend_data_next = pend_data_reg;

        if (state_reg != ST_IDLE) begin
            wdog_next = wdog_reg + WD_W'(1);
        end

        if (fe) begin
            wdog_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (!dat) begin
                        state_next = ST_DATA;
                        cnt_next   = '0;
                    end
                end
                ST_DATA: begin
                    // LSB arrives first, so after DATA_W shifts it sits in bit 0.
                    shift_next = {dat, shift_reg[DATA_W-1:1]};
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                        state_next = (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    pbit_next  = dat;
                    state_next = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    if (!dat) begin
                        frm_err_next = 1'b1;
                    end else if (!par_ok) begin
                        par_err_next = 1'b1;
                    end else begin
                        pend_next      = 1'b1;
                        pend_data_next = shift_reg;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if ((state_reg != ST_IDLE) && (wdog_next == WD_W'(TIMEOUT_CYC))) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            wdog_next  = '0;
            tmo_next   = 1'b1;
        end
    end

    // A completed frame is offered to the buffer one cycle after its stop edge.
    always_ff @(posedge CLKOUT or negedge RST_N) begin
        if (!RST_N) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            ovr_reg <= 1'b0;
            if (pend_reg) begin
                if (!valid_reg || READY) begin
                    data_reg  <= pend_data_reg;
                    valid_reg <= 1'b1;
                end else begin
                    ovr_reg <= 1'b1;
                end
            end else if (valid_reg && READY) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign DATA    = data_reg;
    assign VALID   = valid_reg;
    assign PAR_ERR = par_err_reg;
    assign FRM_ERR = frm_err_reg;
    assign OVERRUN = ovr_reg;
    assign TIMEOUT = tmo_reg;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: table-driven frames plus hand-written
// overrun, timeout, glitch, reset and no-parity sequences, scored via queues.
module tb_ps2_rx_frame;
    import ps2_pkg::*;

    localparam int S    = 2;
    localparam int F    = 4;
    localparam int T    = 5000;
    localparam int HALF = 20;

    logic CLKOUT  = 1'b0;
    logic RST_N   = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic ready   = 1'b1;
    logic sel2    = 1'b0;

    logic       clk1, dat1, clk2, dat2;
    logic [7:0] data1;
    logic [6:0] data2;
    logic       valid1, par1, frm1, ovr1, tmo1;
    logic       valid2, par2, frm2, ovr2, tmo2;

    assign clk1 = sel2 ? 1'b1 : ps2_clk;
    assign dat1 = sel2 ? 1'b1 : ps2_dat;
    assign clk2 = sel2 ? ps2_clk : 1'b1;
    assign dat2 = sel2 ? ps2_dat : 1'b1;

    always #5 CLKOUT = ~CLKOUT;

    ps2_rx_frame u_dut1 (
        .CLKOUT(CLKOUT), .RST_N(RST_N), .PS2_CLK(clk1), .PS2_DAT(dat1),
        .DATA(data1), .VALID(valid1), .READY(ready),
        .PAR_ERR(par1), .FRM_ERR(frm1), .OVERRUN(ovr1), .TIMEOUT(tmo1)
    );

    ps2_rx_frame #(.DATA_W(7), .PARITY_MODE(2)) u_dut2 (
        .CLKOUT(CLKOUT), .RST_N(RST_N), .PS2_CLK(clk2), .PS2_DAT(dat2),
        .DATA(data2), .VALID(valid2), .READY(ready),
        .PAR_ERR(par2), .FRM_ERR(frm2), .OVERRUN(ovr2), .TIMEOUT(tmo2)
    );

    typedef enum int {EV_LOAD, EV_PAR, EV_FRM, EV_OVR, EV_TMO} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [8:0] data;
    } ev_t;
    typedef struct {
        logic [7:0] d;
        logic       par_bad;
        logic       stop;
        ev_kind_t   exp_kind;
    } vec_t;

    ev_t q1[$];
    ev_t q2[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int which, input ev_kind_t k, input logic [8:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        if (which == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic sb_check(input int which, input ev_kind_t k, input logic [8:0] d);
        ev_t e;
        bit  empty;
        checks++;
        empty = (which == 1) ? (q1.size() == 0) : (q2.size() == 0);
        if (empty) begin
            failures++;
            $display("FAIL sb%0d_unexpected actual kind=%0d data=%0h required=no event", which, k, d);
        end else begin
            if (which == 1) e = q1.pop_front();
            else e = q2.pop_front();
            if (e.kind != k || e.data !== d) begin
                failures++;
                $display("FAIL sb%0d_event actual kind=%0d data=%0h required kind=%0d data=%0h",
                         which, k, d, e.kind, e.data);
            end
        end
    endtask

    // Output monitor: a load is VALID high after an empty or accepting cycle.
    logic pv1 = 1'b0;
    logic pv2 = 1'b0;
    always @(posedge CLKOUT) begin
        #1;
        if (RST_N) begin
            if ((int'(par1) + int'(frm1) + int'(ovr1) + int'(tmo1)) > 1) begin
                checks++;
                failures++;
                $display("FAIL pulse_excl1 actual=%b%b%b%b required=at most one", par1, frm1, ovr1, tmo1);
            end
            if (valid1 && (!pv1 || ready)) sb_check(1, EV_LOAD, {1'b0, data1});
            if (par1) sb_check(1, EV_PAR, 9'h0);
            if (frm1) sb_check(1, EV_FRM, 9'h0);
            if (ovr1) sb_check(1, EV_OVR, 9'h0);
            if (tmo1) sb_check(1, EV_TMO, 9'h0);
            if (valid2 && (!pv2 || ready)) sb_check(2, EV_LOAD, {2'b00, data2});
            if (par2) sb_check(2, EV_PAR, 9'h0);
            if (frm2) sb_check(2, EV_FRM, 9'h0);
            if (ovr2) sb_check(2, EV_OVR, 9'h0);
            if (tmo2) sb_check(2, EV_TMO, 9'h0);
        end
        pv1 = valid1;
        pv2 = valid2;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLKOUT);
    endtask

    task automatic drive_bits(input logic [11:0] bits, input int n, input logic [11:0] glitch);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            if (glitch[i]) begin
                wait_cyc(6);
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 8);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        wait_cyc(HALF);
    endtask

    function automatic logic [11:0] frame1(input logic [7:0] d, input logic par_bad, input logic stop);
        logic p;
        p = ~(^d) ^ par_bad;
        return {1'b0, stop, p, d, 1'b0};
    endfunction

    function automatic logic [11:0] frame2(input logic [6:0] d);
        return {3'b000, 1'b1, d, 1'b0};
    endfunction

    vec_t       vecs[8];
    logic [7:0] last_good;
    int         n1, n2, got;
    logic [11:0] fr;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        n1 = ps2_frame_len(8, PAR_ODD);
        n2 = ps2_frame_len(7, PAR_NONE);
        vecs[0] = '{8'h1C, 1'b0, 1'b1, EV_LOAD};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, EV_PAR};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, EV_FRM};
        vecs[3] = '{8'h1C, 1'b1, 1'b0, EV_FRM};
        vecs[4] = '{8'h00, 1'b0, 1'b1, EV_LOAD};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, EV_LOAD};
        vecs[6] = '{8'h80, 1'b1, 1'b1, EV_PAR};
        vecs[7] = '{8'hA5, 1'b0, 1'b1, EV_LOAD};

        wait_cyc(4);
        check("rst_data", data1, 0);
        check("rst_valid", valid1, 0);
        check("rst_pulses", {par1, frm1, ovr1, tmo1}, 0);
        RST_N = 1'b1;
        wait_cyc(4);

        // Table: good, parity-error and framing-error frames with READY high.
        last_good = 8'h00;
        for (int i = 0; i < 8; i++) begin
            push(1, vecs[i].exp_kind, (vecs[i].exp_kind == EV_LOAD) ? {1'b0, vecs[i].d} : 9'h0);
            if (vecs[i].exp_kind == EV_LOAD) last_good = vecs[i].d;
            drive_bits(frame1(vecs[i].d, vecs[i].par_bad, vecs[i].stop), n1, 12'h0);
            check($sformatf("vec%0d_data", i), data1, last_good);
            check($sformatf("vec%0d_valid", i), valid1, 0);
            check($sformatf("vec%0d_sb_empty", i), q1.size(), 0);
        end

        // Overrun: buffer held full, second frame dropped.
        ready = 1'b0;
        push(1, EV_LOAD, 9'h01C);
        drive_bits(frame1(8'h1C, 1'b0, 1'b1), n1, 12'h0);
        check("ovr_first_data", data1, 8'h1C);
        check("ovr_first_valid", valid1, 1);
        push(1, EV_OVR, 9'h0);
        drive_bits(frame1(8'h32, 1'b0, 1'b1), n1, 12'h0);
        check("ovr_keep_data", data1, 8'h1C);
        check("ovr_keep_valid", valid1, 1);
        // READY raised only on the completion cycle of 0x45.
        push(1, EV_LOAD, 9'h045);
        fr = frame1(8'h45, 1'b0, 1'b1);
        drive_bits(fr, n1 - 1, 12'h0);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(S + F + 1);
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
        wait_cyc(HALF - S - F - 2);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        check("swap_data", data1, 8'h45);
        check("swap_valid", valid1, 1);
        ready = 1'b1;
        wait_cyc(3);
        check("drain_valid", valid1, 0);
        check("ovr_sb_empty", q1.size(), 0);

        // Timeout after start + 4 data bits.
        push(1, EV_TMO, 9'h0);
        fr = frame1(8'hF0, 1'b0, 1'b1);
        drive_bits(fr, 4, 12'h0);
        ps2_dat = fr[4];
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        got = -1;
        for (int n = 1; n <= T + 200; n++) begin
            wait_cyc(1);
            if (n == HALF) ps2_clk = 1'b1;
            if (tmo1) begin
                got = n;
                break;
            end
        end
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        check("timeout_cycles", got, S + F + 1 + T);
        wait_cyc(HALF);
        push(1, EV_LOAD, 9'h0F0);
        drive_bits(frame1(8'hF0, 1'b0, 1'b1), n1, 12'h0);
        check("after_tmo_data", data1, 8'hF0);
        check("tmo_sb_empty", q1.size(), 0);

        // Short clock glitches mid-frame are filtered out.
        push(1, EV_LOAD, 9'h0AA);
        drive_bits(frame1(8'hAA, 1'b0, 1'b1), n1, 12'b0001_0101_0100);
        check("glitch_data", data1, 8'hAA);

        // Reset mid-frame, then a fresh frame.
        drive_bits(frame1(8'h33, 1'b0, 1'b1), 4, 12'h0);
        RST_N = 1'b0;
        wait_cyc(5);
        RST_N = 1'b1;
        wait_cyc(HALF);
        check("midrst_data", data1, 0);
        check("midrst_valid", valid1, 0);
        push(1, EV_LOAD, 9'h055);
        drive_bits(frame1(8'h55, 1'b0, 1'b1), n1, 12'h0);
        check("after_rst_data", data1, 8'h55);
        check("rst_sb_empty", q1.size(), 0);

        // Seven data bits, no parity bit on the wire.
        sel2 = 1'b1;
        wait_cyc(4);
        push(2, EV_LOAD, 9'h041);
        drive_bits(frame2(7'h41), n2, 12'h0);
        check("np_data_41", data2, 7'h41);
        push(2, EV_LOAD, 9'h03E);
        drive_bits(frame2(7'h3E), n2, 12'h0);
        check("np_data_3e", data2, 7'h3E);
        sel2 = 1'b0;
        wait_cyc(4);
        check("np_sb_empty", q2.size(), 0);
        check("final_sb1_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Parametrised PS/2 device-to-host frame receiver for the keyboard/touch path, running on the system clock.
- Synchronises and glitch-filters the raw PS2_CLK/PS2_DAT pins.
- Decodes start/data/parity/stop with selectable parity mode and an inter-edge watchdog.
- Presents each good byte through a one-entry valid/ready holding buffer, with parity, framing, overrun and timeout status pulses.
- Feeds the scan-code decoder.

Parameters:
- DATA_W, 8: data bits per frame, LSB first; legal 5..9.
- PARITY_MODE, 1: 1 = odd, 0 = even, 2 = none (no parity bit on the wire).
- SYNC_STAGES, 2: synchroniser flops on each pin; legal 2..3.
- FILT_LEN, 4: consecutive equal samples required before the filtered PS2_CLK level changes.
- TIMEOUT_CYC, 5000: CLKOUT cycles allowed between falling edges inside a frame.

Ports:
- CLKOUT in 1: system clock, all logic rising-edge.
- RST_N in 1: reset, asynchronous assert, active-low.
- PS2_CLK in 1: raw PS/2 clock pin, asynchronous.
- PS2_DAT in 1: raw PS/2 data pin, asynchronous.
- DATA out DATA_W: received byte, valid while VALID=1.
- VALID out 1: holding buffer full.
- READY in 1: consumer accepts DATA when VALID&&READY.
- PAR_ERR out 1: one-cycle pulse, parity mismatch.
- FRM_ERR out 1: one-cycle pulse, stop bit sampled 0.
- OVERRUN out 1: one-cycle pulse, good frame dropped because buffer full.
- TIMEOUT out 1: one-cycle pulse, frame aborted by watchdog.

Behaviour:
- Reset values: DATA=0, VALID=0, all pulse outputs=0, FSM=IDLE, bit count=0, watchdog=0, filtered clock=1, sync flops=1.
- Edge detection:
  - Filtered PS2_CLK changes only after FILT_LEN identical synchronised samples.
  - A 1->0 change of the filtered level generates a one-cycle strobe FE.
  - PS2_DAT is sampled from its last sync stage on the FE cycle.
  - FE follows a clean pin fall by SYNC_STAGES+FILT_LEN cycles.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: FE with dat=0 -> DATA, count=0. FE with dat=1 is ignored, with no flag.
  - DATA: each FE shifts dat into bit[count], count++. After DATA_W bits -> PARITY, or -> STOP if PARITY_MODE=2.
  - PARITY: FE captures the parity bit -> STOP.
  - STOP: FE -> IDLE. The frame is good iff the stop bit=1 and the parity check passes.
- Parity check: XOR of data bits XOR parity bit must equal 1 for odd and 0 for even.
- Frame errors:
  - Stop=0 pulses FRM_ERR only, even if parity is also bad.
  - Otherwise a bad parity pulses PAR_ERR.
  - In both cases DATA and VALID are unchanged.
- Good-frame handling, evaluated on the cycle after the STOP FE:
  - If VALID=0, or VALID&&READY on that cycle: load DATA, VALID=1.
  - Else keep the old DATA and VALID=1, drop the new frame, pulse OVERRUN.
- VALID clears on the cycle after VALID&&READY unless a load occurs that same cycle.
- Watchdog: counts every cycle while FSM!=IDLE and clears on every FE.
  - Reaching TIMEOUT_CYC forces IDLE and count=0, and pulses TIMEOUT.
  - The partial frame is discarded.
- Pulse outputs are registered, exactly one CLKOUT wide, and never asserted together.
- RST_N low mid-frame aborts immediately, with no pulses.
  - The first FE after release with dat=0 starts a fresh frame.
- Inter-frame gap: none required. An FE with dat=0 in IDLE on the cycle after the STOP FE starts the next frame.

Decomposition:
- Package ps2_pkg: FSM state enum, parity-mode constants PAR_EVEN=0, PAR_ODD=1, PAR_NONE=2, and a frame-length function DATA_W+2+(PARITY_MODE!=2).
- Sub-module ps2_edge_filt: synchroniser for both pins, FILT_LEN glitch filter on the clock, FE strobe, synchronised data out.
- Top level contains the FSM, shifter, watchdog and holding buffer.

Test Plan:
1. Defaults, READY=1, frame 0x1C with odd parity bit 0 and stop 1 -> VALID pulse for one cycle, DATA=0x1C, no error pulses.
2. Frame 0x1C with parity bit 1 -> PAR_ERR one cycle, VALID stays 0. Repeat with parity 0 and stop 0 -> FRM_ERR only.
3. READY=0, send 0x1C then 0x32 -> DATA stays 0x1C, VALID=1, one OVERRUN pulse. Assert READY on the 0x45 completion cycle -> DATA=0x45, no OVERRUN.
4. Send start plus 4 bits, then hold PS2_CLK high -> TIMEOUT exactly TIMEOUT_CYC cycles after the last FE. A following 0xF0 frame decodes correctly.
5. Insert 2-cycle low glitches on PS2_CLK mid-frame (FILT_LEN=4) -> ignored, 0xAA decodes correctly. RST_N low after bit 3 -> no outputs, next frame 0x55 correct.
6. DATA_W=7, PARITY_MODE=2, frame 0x41 -> DATA=0x41 after 9 FEs, no parity bit consumed.
